// File: rtl/exhaustive_stim_seq.sv
// Stimulus sequencer: sweeps a WIDTH-bit pattern upward from START_VAL, holding each for DWELL clocks.
// Optional response checker enabled by defining STIM_CHECK_EN.
module exhaustive_stim_seq #(
    parameter int WIDTH     = 4,
    parameter int N_STEPS   = 18,
    parameter int DWELL     = 1000,
    parameter int START_VAL = 0,
    parameter int STEP_W    = 16,
    parameter int ERR_W     = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_hold,
    input  logic              i_abort,
    output logic [WIDTH-1:0]  o_pattern,
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic [STEP_W-1:0] o_step
`ifdef STIM_CHECK_EN
    ,
    input  logic              i_dut_out,
    input  logic              i_exp_out,
    output logic [ERR_W-1:0]  o_err_cnt,
    output logic              o_pass
`endif
);

    localparam int TMR_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [TMR_W-1:0]  DWELL_LAST = TMR_W'(DWELL - 1);
    localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(N_STEPS - 1);
    localparam logic [WIDTH-1:0]  FIRST_PAT  = WIDTH'(START_VAL);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [WIDTH-1:0]  pattern_q, pattern_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [STEP_W-1:0] step_q, step_d;

`ifdef STIM_CHECK_EN
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              pass_q, pass_d;
    logic [ERR_W-1:0]  err_scored;

    // Saturating score of this clock's compare, used only on a pattern's last dwell clock.
    assign err_scored = ((i_dut_out != i_exp_out) && (err_cnt_q != '1))
                        ? err_cnt_q + 1'b1 : err_cnt_q;
`endif

    always_comb begin
        // NOTE: every _d gets a default before any branch so no path leaves it unassigned (no latch).
        state_d   = state_q;
        timer_d   = timer_q;
        pattern_d = pattern_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        step_d    = step_q;
`ifdef STIM_CHECK_EN
        err_cnt_d = err_cnt_q;
        pass_d    = pass_q;
`endif

        if (i_abort) begin
            // Step index and error count survive an abort for post-mortem inspection.
            state_d   = ST_IDLE;
            timer_d   = '0;
            pattern_d = '0;
            valid_d   = 1'b0;
            busy_d    = 1'b0;
`ifdef STIM_CHECK_EN
            pass_d    = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_d   = ST_RUN;
                        timer_d   = '0;
                        pattern_d = FIRST_PAT;
                        valid_d   = 1'b1;
                        busy_d    = 1'b1;
                        step_d    = '0;
`ifdef STIM_CHECK_EN
                        err_cnt_d = '0;
                        pass_d    = 1'b0;
`endif
                    end
                end
                ST_RUN: begin
                    if (!i_hold) begin
                        if (timer_q == DWELL_LAST) begin
                            timer_d = '0;
`ifdef STIM_CHECK_EN
                            err_cnt_d = err_scored;
`endif
                            if (step_q == STEP_LAST) begin
                                state_d   = ST_DONE;
                                pattern_d = '0;
                                valid_d   = 1'b0;
                                busy_d    = 1'b0;
                                done_d    = 1'b1;
`ifdef STIM_CHECK_EN
                                pass_d    = (err_scored == '0);
`endif
                            end else begin
                                step_d    = step_q + 1'b1;
                                pattern_d = pattern_q + 1'b1;
                            end
                        end else begin
                            timer_d = timer_q + 1'b1;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            pattern_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            step_q    <= '0;
`ifdef STIM_CHECK_EN
            err_cnt_q <= '0;
            pass_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pattern_q <= pattern_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            step_q    <= step_d;
`ifdef STIM_CHECK_EN
            err_cnt_q <= err_cnt_d;
            pass_q    <= pass_d;
`endif
        end
    end

    assign o_pattern = pattern_q;
    assign o_valid   = valid_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_step    = step_q;
`ifdef STIM_CHECK_EN
    assign o_err_cnt = err_cnt_q;
    assign o_pass    = pass_q;
`endif

endmodule

// File: tb/tb_exhaustive_stim_seq.sv
// Bench for exhaustive_stim_seq: elapsed-clock reference model checked every cycle plus directed
// scenario checks on recorded waveforms.
module tb_exhaustive_stim_seq;

    localparam int W      = 4;
    localparam int N      = 18;
    localparam int D      = 4;
    localparam int SV     = 0;
    localparam int STEP_W = 16;
    localparam int ERR_W  = 16;
    localparam int MAXC   = 128;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_start = 1'b0;
    logic              i_hold = 1'b0;
    logic              i_abort = 1'b0;
    logic              i_dut_out = 1'b0;
    logic              i_exp_out = 1'b0;
    logic [W-1:0]      o_pattern;
    logic              o_valid;
    logic              o_busy;
    logic              o_done;
    logic [STEP_W-1:0] o_step;
`ifdef STIM_CHECK_EN
    logic [ERR_W-1:0]  o_err_cnt;
    logic              o_pass;
`endif

    exhaustive_stim_seq #(
        .WIDTH(W), .N_STEPS(N), .DWELL(D), .START_VAL(SV), .STEP_W(STEP_W), .ERR_W(ERR_W)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (i_start),
        .i_hold   (i_hold),
        .i_abort  (i_abort),
        .o_pattern(o_pattern),
        .o_valid  (o_valid),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_step   (o_step)
`ifdef STIM_CHECK_EN
        ,
        .i_dut_out(i_dut_out),
        .i_exp_out(i_exp_out),
        .o_err_cnt(o_err_cnt),
        .o_pass   (o_pass)
`endif
    );

    always #5 i_clk = ~i_clk;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a run is just a count of unheld clocks since start.
    bit m_active  = 1'b0;
    bit m_done    = 1'b0;
    bit m_pass    = 1'b0;
    int m_elapsed = 0;
    int m_err     = 0;

    function automatic int err_after(input int e, input bit mis);
        return (mis && e < (1 << ERR_W) - 1) ? e + 1 : e;
    endfunction

    always @(posedge i_clk) begin
        if (i_rst) begin
            m_active <= 1'b0; m_done <= 1'b0; m_pass <= 1'b0; m_elapsed <= 0; m_err <= 0;
        end else if (i_abort) begin
            m_active <= 1'b0; m_done <= 1'b0; m_pass <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (!m_active) begin
            if (i_start) begin
                m_active <= 1'b1; m_elapsed <= 0; m_err <= 0; m_pass <= 1'b0;
            end
        end else if (!i_hold) begin
            m_elapsed <= m_elapsed + 1;
            if (m_elapsed % D == D - 1) begin
                m_err <= err_after(m_err, i_dut_out != i_exp_out);
                if (m_elapsed == N * D - 1) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                    m_pass   <= (err_after(m_err, i_dut_out != i_exp_out) == 0);
                end
            end
        end
    end

    always @(negedge i_clk) begin
        if (cmp_en) begin
            check("valid", o_valid, m_active);
            check("busy", o_busy, m_active);
            check("done", o_done, m_done);
            check("pattern", o_pattern, m_active ? (SV + m_elapsed / D) % (1 << W) : 0);
            check("step", o_step, (m_elapsed / D > N - 1) ? N - 1 : m_elapsed / D);
`ifdef STIM_CHECK_EN
            check("err_cnt", o_err_cnt, m_err);
            check("pass", o_pass, m_pass);
`endif
        end
    end

    int obs_valid[MAXC];
    int obs_busy[MAXC];
    int obs_done[MAXC];
    int obs_pat[MAXC];
    int obs_step[MAXC];
    int obs_err[MAXC];
    int obs_pass[MAXC];

    // Cycle c inputs are sampled at edge c; obs[c+1] holds outputs after that edge.
    task automatic run_test(input int n_cyc, input int st_a, input int st_b, input int st_c,
                            input int st_d, input int hold_lo, input int hold_hi,
                            input int abort_at, input int rst_at, input int mis_lo,
                            input int mis_hi);
        i_rst = 1'b1; i_start = 1'b0; i_hold = 1'b0; i_abort = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int i = 0; i < MAXC; i++) begin
            obs_valid[i] = 0; obs_busy[i] = 0; obs_done[i] = 0; obs_pat[i] = 0;
            obs_step[i] = 0; obs_err[i] = 0; obs_pass[i] = 0;
        end
        for (int c = 0; c < n_cyc; c++) begin
            i_start   = (c == st_a) || (c == st_b) || (c == st_c) || (c == st_d);
            i_hold    = (c >= hold_lo) && (c <= hold_hi);
            i_abort   = (c == abort_at);
            i_rst     = (c == rst_at);
            i_dut_out = c[0];
            i_exp_out = ((c >= mis_lo) && (c <= mis_hi)) ? ~c[0] : c[0];
            @(negedge i_clk);
            obs_valid[c+1] = int'(o_valid);
            obs_busy[c+1]  = int'(o_busy);
            obs_done[c+1]  = int'(o_done);
            obs_pat[c+1]   = int'(o_pattern);
            obs_step[c+1]  = int'(o_step);
`ifdef STIM_CHECK_EN
            obs_err[c+1]   = int'(o_err_cnt);
            obs_pass[c+1]  = int'(o_pass);
`endif
        end
        i_start = 1'b0; i_hold = 1'b0; i_abort = 1'b0; i_rst = 1'b0;
    endtask

    function automatic int first_done();
        for (int i = 0; i < MAXC; i++) if (obs_done[i] != 0) return i;
        return -1;
    endfunction

    function automatic int count_done();
        int n = 0;
        for (int i = 0; i < MAXC; i++) n += obs_done[i];
        return n;
    endfunction

    function automatic int count_valid(input int pat);
        int n = 0;
        for (int i = 0; i < MAXC; i++)
            if (obs_valid[i] != 0 && (pat < 0 || obs_pat[i] == pat)) n++;
        return n;
    endfunction

    initial begin
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        check("rst_valid", o_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_pattern", o_pattern, 0);
        check("rst_step", o_step, 0);
        cmp_en = 1'b1;

        // Plain run.
        run_test(80, 0, -1, -1, -1, -1, -1, -1, -1, -1, -1);
        check("t1_first_pat", obs_pat[1], 0);
        check("t1_first_valid", obs_valid[1], 1);
        check("t1_pat5_start", obs_pat[5], 1);
        check("t1_wrap_pat", obs_pat[69], 1);
        check("t1_last_valid", obs_valid[72], 1);
        check("t1_done_at", first_done(), 73);
        check("t1_done_count", count_done(), 1);
        check("t1_valid_clocks", count_valid(-1), 72);
        check("t1_done_pat", obs_pat[73], 0);
        check("t1_done_busy", obs_busy[73], 0);
        check("t1_step_kept", obs_step[79], 17);

        // Hold stretches pattern 2.
        run_test(85, 0, -1, -1, -1, 10, 14, -1, -1, -1, -1);
        check("t2_pat2_clocks", count_valid(2), 9);
        check("t2_done_at", first_done(), 78);
        check("t2_valid_clocks", count_valid(-1), 77);

        // Abort mid-run.
        run_test(80, 0, -1, -1, -1, -1, -1, 20, -1, -1, -1);
        check("t3_pat_before", obs_pat[20], 4);
        check("t3_valid_after", obs_valid[21], 0);
        check("t3_busy_after", obs_busy[21], 0);
        check("t3_pat_after", obs_pat[21], 0);
        check("t3_step_kept", obs_step[21], 4);
        check("t3_no_done", count_done(), 0);

        // Starts during RUN and DONE ignored; start in IDLE after DONE accepted.
        run_test(80, 0, 5, 73, 74, -1, -1, -1, -1, -1, -1);
        check("t4_no_restart", obs_pat[10], 2);
        check("t4_done_at", first_done(), 73);
        check("t4_idle_74", obs_valid[74], 0);
        check("t4_restart_valid", obs_valid[75], 1);
        check("t4_restart_pat", obs_pat[75], 0);
        check("t4_restart_step", obs_step[75], 0);

        // Synchronous reset mid-run, then a fresh start.
        run_test(45, 0, 32, -1, -1, -1, -1, -1, 30, -1, -1);
        check("t6_pat_before", obs_pat[30], 7);
        check("t6_valid_rst", obs_valid[31], 0);
        check("t6_step_rst", obs_step[31], 0);
        check("t6_busy_rst", obs_busy[31], 0);
        check("t6_fresh_valid", obs_valid[33], 1);
        check("t6_fresh_pat", obs_pat[33], 0);
        check("t6_fresh_pat1", obs_pat[37], 1);

`ifdef STIM_CHECK_EN
        // Mismatch only while pattern 5 is driven (cycles 21..24).
        run_test(80, 0, -1, -1, -1, -1, -1, -1, -1, 21, 24);
        check("t5_err_mid", obs_err[24], 0);
        check("t5_err_after", obs_err[25], 1);
        check("t5_err_done", obs_err[73], 1);
        check("t5_pass_done", obs_pass[73], 0);
        run_test(80, 0, -1, -1, -1, -1, -1, -1, -1, -1, -1);
        check("t5_clean_err", obs_err[73], 0);
        check("t5_clean_pass", obs_pass[73], 1);
        check("t5_pass_held", obs_pass[79], 1);
`endif

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
